// File: rtl/riscv_immext_pipe_pkg.sv
// rtl/riscv_immext_pipe_pkg.sv - imm-source codes and widths shared by the immediate extender
package riscv_immext_pipe_pkg;

  localparam int IMM_SRC_W = 3;

  // Codes 0..4 are the base RV formats; 5 and 6 are the CSR uimm and shift-amount forms.
  // Code 7 is unassigned and reported as illegal.
  typedef enum logic [IMM_SRC_W-1:0] {
    INSTR_I_TYPE  = 3'd0,
    INSTR_S_TYPE  = 3'd1,
    INSTR_B_TYPE  = 3'd2,
    INSTR_U_TYPE  = 3'd3,
    INSTR_J_TYPE  = 3'd4,
    INSTR_Z_TYPE  = 3'd5,
    INSTR_SH_TYPE = 3'd6
  } imm_src_e;

endpackage

// File: rtl/riscv_immext_core.sv
// rtl/riscv_immext_core.sv - combinational XLEN-parametrised immediate extender with illegal-code flag
module riscv_immext_core
  import riscv_immext_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]      imm_ext,
  output logic                 err
);

  // Every format fits in 32 bits; only the final widening to XLEN depends on signedness.
  logic [31:0] imm32;
  logic        sext;

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = &{1'b0, instr[6:0]};

  // Select the immediate field layout for the requested format.
  always_comb begin
    imm32 = '0;
    sext  = 1'b0;
    err   = 1'b0;
    case (imm_src_e'(imm_src))
      INSTR_I_TYPE: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        sext  = 1'b1;
      end
      INSTR_S_TYPE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        sext  = 1'b1;
      end
      INSTR_B_TYPE: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        sext  = 1'b1;
      end
      INSTR_U_TYPE: begin
        imm32 = {instr[31:12], 12'b0};
        sext  = 1'b1;
      end
      INSTR_J_TYPE: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        sext  = 1'b1;
      end
      INSTR_Z_TYPE: begin
        imm32 = {27'b0, instr[19:15]};
      end
      INSTR_SH_TYPE: begin
        // RV64 shifts use a 6-bit shamt, RV32 only 5 bits.
        imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

  assign imm_ext = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

endmodule

// File: rtl/riscv_immext_pipe.sv
// rtl/riscv_immext_pipe.sv - registered valid/ready immediate extender with a one-entry skid buffer
module riscv_immext_pipe
  import riscv_immext_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BW_INSTR = 32,
  parameter int BW_CTRL  = 3,
  parameter int BW_TAG   = 32
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [BW_INSTR-1:0] i_instr,
  input  logic [BW_CTRL-1:0]  i_imm_src,
  input  logic [BW_TAG-1:0]   i_tag,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [XLEN-1:0]     o_imm_ext,
  output logic [BW_TAG-1:0]   o_tag,
  output logic                o_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("riscv_immext_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]   core_imm;
  logic              core_err;

  logic              main_valid;
  logic [XLEN-1:0]   main_imm;
  logic [BW_TAG-1:0] main_tag;
  logic              main_err;

  logic              skid_valid;
  logic [XLEN-1:0]   skid_imm;
  logic [BW_TAG-1:0] skid_tag;
  logic              skid_err;

  logic              in_xfer;
  logic              main_free;

  riscv_immext_core #(
    .XLEN (XLEN)
  ) u_core (
    .instr   (i_instr),
    .imm_src (i_imm_src),
    .imm_ext (core_imm),
    .err     (core_err)
  );

  // Ready depends only on the registered skid flag, so there is no path from i_ready.
  assign o_ready   = !skid_valid;
  assign in_xfer   = i_valid && o_ready;
  // Main register can take a new entry when it is empty or draining this cycle.
  assign main_free = !main_valid || i_ready;

  assign o_valid   = main_valid;
  assign o_imm_ext = main_imm;
  assign o_tag     = main_tag;
  assign o_err     = main_err;

  // Main/skid pipeline: skid refills main first so FIFO order holds; flush drops both entries.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (i_flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // o_ready is low while the skid is full, so no input can arrive here.
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_valid <= 1'b1;
        main_imm   <= core_imm;
        main_tag   <= i_tag;
        main_err   <= core_err;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_imm   <= core_imm;
      skid_tag   <= i_tag;
      skid_err   <= core_err;
    end
  end

  a_stall_hold: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    (o_valid && !i_ready && !i_flush) |=>
      (o_valid && $stable(o_imm_ext) && $stable(o_tag) && $stable(o_err))
  );

endmodule

// File: tb/tb_riscv_immext_pipe.sv
// tb/tb_riscv_immext_pipe.sv - randomized and directed bench for riscv_immext_pipe at XLEN 32 and 64
module tb_riscv_immext_pipe;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        valid;
  logic [31:0] instr;
  logic [2:0]  src;
  logic [31:0] tag;
  logic        rdy;

  logic        ready32, valid32, err32;
  logic [31:0] imm32, tag32;
  logic        ready64, valid64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [31:0] tag;
    logic        err;
  } entry_t;

  entry_t q[$];

  riscv_immext_pipe #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(ready32),
    .i_instr(instr), .i_imm_src(src), .i_tag(tag), .o_valid(valid32), .i_ready(rdy),
    .o_imm_ext(imm32), .o_tag(tag32), .o_err(err32)
  );

  riscv_immext_pipe #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(ready64),
    .i_instr(instr), .i_imm_src(src), .i_tag(tag), .o_valid(valid64), .i_ready(rdy),
    .o_imm_ext(imm64), .o_tag(tag64), .o_err(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference immediate from arithmetic on the instruction value, XLEN 64 result.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int code, input int xlen,
                                          output logic err);
    int     si;
    longint s, v, b;
    si  = ins;
    s   = si;
    err = 1'b0;
    case (code)
      0: v = s >>> 20;
      1: v = ((s >>> 20) & ~longint'(31)) | longint'((ins >> 7) & 32'h1F);
      2: begin
        b = ins[31] ? -4096 : 0;
        v = b + longint'(ins[7]) * 2048 + longint'((ins >> 25) & 32'h3F) * 32
              + longint'((ins >> 8) & 32'hF) * 2;
      end
      3: v = s & ~longint'(32'hFFF);
      4: begin
        b = ins[31] ? -1048576 : 0;
        v = b + longint'((ins >> 12) & 32'hFF) * 4096 + longint'(ins[20]) * 2048
              + longint'((ins >> 21) & 32'h3FF) * 2;
      end
      5: v = longint'((ins >> 15) & 32'h1F);
      6: v = longint'((ins >> 20) & ((xlen == 64) ? 32'h3F : 32'h1F));
      default: begin
        v   = 0;
        err = 1'b1;
      end
    endcase
    return v;
  endfunction

  function automatic entry_t mk(input logic [31:0] ins, input logic [2:0] code, input logic [31:0] tg);
    entry_t      e;
    logic        e64, e32;
    logic [63:0] r32;
    e.imm64 = ref_imm(ins, int'(code), 64, e64);
    r32     = ref_imm(ins, int'(code), 32, e32);
    e.imm32 = r32[31:0];
    e.tag   = tg;
    e.err   = e64 | e32;
    return e;
  endfunction

  task automatic check_outputs();
    logic exp_v;
    exp_v = (q.size() > 0);
    check("valid32", valid32, exp_v);
    check("valid64", valid64, exp_v);
    check("ready32", ready32, q.size() < 2);
    check("ready64", ready64, q.size() < 2);
    if (exp_v) begin
      check("imm32", imm32, q[0].imm32);
      check("imm64", imm64, q[0].imm64);
      check("tag32", tag32, q[0].tag);
      check("tag64", tag64, q[0].tag);
      check("err32", err32, q[0].err);
      check("err64", err64, q[0].err);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the occupancy model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] code,
                       input logic [31:0] tg, input logic r, input logic fl);
    logic in_x, out_x;
    valid = v; instr = ins; src = code; tag = tg; rdy = r; flush = fl;
    @(negedge clk);
    check_outputs();
    in_x  = v && (q.size() < 2) && !fl;
    out_x = (q.size() > 0) && r;
    if (fl) q.delete();
    else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(mk(ins, code, tg));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 32'h0, 3'd0, 32'h0, r, 1'b0);
  endtask

  logic [31:0] d_instr [6] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                               32'h123450B7, 32'hFFDFF06F, 32'h000FD073};
  logic [31:0] d_exp   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                               32'h12345000, 32'hFFFFFFFC, 32'h0000001F};

  initial begin
    rstn = 1'b0; flush = 1'b0; valid = 1'b0; instr = '0; src = '0; tag = '0; rdy = 1'b1;
    #23;
    check("rst_valid", valid32, 1'b0);
    check("rst_ready", ready32, 1'b1);
    check("rst_imm32", imm32, 64'h0);
    check("rst_imm64", imm64, 64'h0);
    check("rst_tag", tag32, 64'h0);
    check("rst_err", err32, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Per-type directed vectors, full throughput.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, d_instr[i], 3'(i), 32'h100 + i, 1'b1, 1'b0);
      check("dir_imm32", imm32, d_exp[i]);
      check("dir_tag", tag32, 32'h100 + i);
      check("dir_valid", valid32, 1'b1);
    end
    idle(1'b1);

    // XLEN=64 directed vectors.
    cycle(1'b1, 32'hFFF00093, 3'd0, 32'h200, 1'b1, 1'b0);
    check("x64_i", imm64, 64'hFFFFFFFFFFFFFFFF);
    cycle(1'b1, 32'h80000037, 3'd3, 32'h201, 1'b1, 1'b0);
    check("x64_u", imm64, 64'hFFFFFFFF80000000);
    cycle(1'b1, 32'h03F01013, 3'd6, 32'h202, 1'b1, 1'b0);
    check("x64_sh", imm64, 64'h3F);
    check("x32_sh", imm32, 64'h1F);
    idle(1'b1);

    // Backpressure: A and B accepted, C held with ready low, then drain in order.
    cycle(1'b1, 32'hFFF00093, 3'd0, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'h123450B7, 3'd3, 32'hB, 1'b0, 1'b0);
    check("bp_ready", ready32, 1'b0);
    cycle(1'b1, 32'hFFDFF06F, 3'd4, 32'hC, 1'b0, 1'b0);
    check("bp_head", tag32, 32'hA);
    cycle(1'b1, 32'hFFDFF06F, 3'd4, 32'hC, 1'b1, 1'b0);
    check("bp_second", tag32, 32'hB);
    cycle(1'b1, 32'hFFDFF06F, 3'd4, 32'hC, 1'b1, 1'b0);
    check("bp_third", tag32, 32'hC);
    idle(1'b1);
    check("bp_drained", valid32, 1'b0);

    // Illegal source followed by a legal one.
    cycle(1'b1, 32'hFFFFFFFF, 3'd7, 32'h300, 1'b1, 1'b0);
    check("ill_err", err32, 1'b1);
    check("ill_imm", imm64, 64'h0);
    cycle(1'b1, 32'hFFF00093, 3'd0, 32'h301, 1'b1, 1'b0);
    check("ill_next_err", err32, 1'b0);
    idle(1'b1);

    // Flush with two entries held; the same-cycle input is dropped.
    cycle(1'b1, 32'h000FD073, 3'd5, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE20AE23, 3'd1, 32'h401, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE000CE3, 3'd2, 32'h402, 1'b0, 1'b1);
    check("flush_valid", valid32, 1'b0);
    check("flush_ready", ready32, 1'b1);
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset while an entry is held.
    cycle(1'b1, 32'hFFF00093, 3'd0, 32'h500, 1'b0, 1'b0);
    check("prerst_valid", valid32, 1'b1);
    valid = 1'b0;
    rstn  = 1'b0;
    #1;
    check("arst_valid32", valid32, 1'b0);
    check("arst_valid64", valid64, 1'b0);
    check("arst_imm", imm64, 64'h0);
    check("arst_tag", tag64, 64'h0);
    check("arst_err", err64, 1'b0);
    check("arst_ready", ready32, 1'b1);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), $urandom, 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
